// File: rtl/cart_pkg.sv
// Shared MBC1 definitions: banking mode, bank sizes, enable key and cartridge region bounds.
package cart_pkg;

  typedef enum logic {
    SIMPLE   = 1'b0,
    ADVANCED = 1'b1
  } mbc_mode_e;

  localparam int ROM_BANK_BYTES = 16384;
  localparam int RAM_BANK_BYTES = 8192;

  localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;

  // Cartridge windows in the CPU address map.
  localparam logic [15:0] ROM_START     = 16'h0000;
  localparam logic [15:0] ROM_END       = 16'h7FFF;
  localparam logic [15:0] EXT_RAM_START = 16'hA000;
  localparam logic [15:0] EXT_RAM_END   = 16'hBFFF;

endpackage

// File: rtl/bus_if.sv
// System bus between the CPU and memory-mapped peripherals.
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;

  modport Peripheral_side (
    input  addr, wdata, read_en, write_en,
    output rdata
  );

  modport Cpu_side (
    output addr, wdata, read_en, write_en,
    input  rdata
  );
endinterface

// File: rtl/mbc1_regs.sv
// MBC1 control registers, their write decode, and the effective ROM/RAM bank numbers.
module mbc1_regs
  import cart_pkg::*;
#(
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_en,
  input  logic [2:0] addr_hi,
  input  logic [4:0] wdata,
  output logic       ram_en,
  output logic [6:0] rom_lo_bank,
  output logic [6:0] rom_hi_bank,
  output logic [1:0] ram_bank
);

  localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);

  logic [4:0] bank1;
  logic [1:0] bank2;
  mbc_mode_e  mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en <= 1'b0;
      bank1  <= 5'd1;
      bank2  <= 2'd0;
      mode   <= SIMPLE;
    end else if (write_en) begin
      case (addr_hi)
        3'b000: ram_en <= (wdata[3:0] == RAM_ENABLE_KEY);
        // Zero test on all five bits, so 0x20/0x40/0x60 never select bank 0 via bank1.
        3'b001: bank1  <= (wdata == 5'd0) ? 5'd1 : wdata;
        3'b010: bank2  <= wdata[1:0];
        3'b011: mode   <= mbc_mode_e'(wdata[0]);
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_hi_bank = {bank2, bank1} & ROM_MASK;
    rom_lo_bank = (mode == ADVANCED) ? ({bank2, 5'd0} & ROM_MASK) : 7'd0;
    ram_bank    = (mode == ADVANCED && RAM_BANKS == 4) ? bank2 : 2'd0;
  end

endmodule

// File: rtl/cartridge_mbc1.sv
// MBC1 cartridge: banked ROM with boot load port, optional banked external RAM, combinational read mux.
module cartridge_mbc1
  import cart_pkg::*;
#(
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4,
  parameter int ROM_AW    = $clog2(ROM_BANKS * ROM_BANK_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  Bus_if.Peripheral_side    bus,
  input  logic              load_en,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              ram_enabled
);

  localparam bit HAS_RAM   = (RAM_BANKS != 0);
  localparam int ROM_DEPTH = ROM_BANKS * ROM_BANK_BYTES;
  localparam int RAM_DEPTH = (HAS_RAM ? RAM_BANKS : 1) * RAM_BANK_BYTES;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  logic              ram_en;
  logic [6:0]        rom_lo_bank;
  logic [6:0]        rom_hi_bank;
  logic [1:0]        ram_bank;
  logic              in_rom;
  logic              in_ram;
  logic [ROM_AW-1:0] rom_idx;
  logic [7:0]        ram_rd;
  logic [7:0]        rom [ROM_DEPTH];

  mbc1_regs #(
    .ROM_BANKS (ROM_BANKS),
    .RAM_BANKS (RAM_BANKS)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .write_en    (bus.write_en),
    .addr_hi     (bus.addr[15:13]),
    .wdata       (bus.wdata[4:0]),
    .ram_en      (ram_en),
    .rom_lo_bank (rom_lo_bank),
    .rom_hi_bank (rom_hi_bank),
    .ram_bank    (ram_bank)
  );

  assign ram_enabled = ram_en;
  assign in_rom      = (bus.addr <= ROM_END);
  assign in_ram      = (bus.addr >= EXT_RAM_START) && (bus.addr <= EXT_RAM_END);

  // Bank numbers are already masked, so the truncation only drops zero bits.
  assign rom_idx = ROM_AW'({(bus.addr[14] ? rom_hi_bank : rom_lo_bank), bus.addr[13:0]});

  always_ff @(posedge clk) begin
    if (load_en) rom[load_addr] <= load_data;
  end

  generate
    if (HAS_RAM) begin : g_ram
      logic [7:0]        ram [RAM_DEPTH];
      logic [RAM_AW-1:0] ram_idx;

      assign ram_idx = RAM_AW'({ram_bank, bus.addr[12:0]});

      always_ff @(posedge clk) begin
        if (bus.write_en && in_ram && ram_en) ram[ram_idx] <= bus.wdata;
      end

      assign ram_rd = ram[ram_idx];
    end else begin : g_no_ram
      assign ram_rd = 8'hFF;
    end
  endgenerate

  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.read_en) begin
      if (in_rom)
        bus.rdata = rom[rom_idx];
      else if (in_ram && ram_en)
        bus.rdata = ram_rd;
    end
  end

endmodule

// File: tb/tb_cartridge_mbc1.sv
// Directed bench for cartridge_mbc1: a 128-bank instance and an 8-bank instance share clock and reset.
module tb_cartridge_mbc1;

  logic        clk;
  logic        reset;
  logic        load_en_a, load_en_b;
  logic [20:0] load_addr_a;
  logic [16:0] load_addr_b;
  logic [7:0]  load_data_a, load_data_b;
  logic        ram_enabled_a, ram_enabled_b;

  int checks;
  int failures;

  Bus_if bus_a ();
  Bus_if bus_b ();

  cartridge_mbc1 #(.ROM_BANKS(128), .RAM_BANKS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_a),
    .load_en     (load_en_a),
    .load_addr   (load_addr_a),
    .load_data   (load_data_a),
    .ram_enabled (ram_enabled_a)
  );

  cartridge_mbc1 #(.ROM_BANKS(8), .RAM_BANKS(4)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_b),
    .load_en     (load_en_b),
    .load_addr   (load_addr_b),
    .load_data   (load_data_b),
    .ram_enabled (ram_enabled_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel = 0 drives the 128-bank instance, sel = 1 the 8-bank instance.
  task automatic bus_write(input bit sel, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    if (!sel) begin
      bus_a.addr = a; bus_a.wdata = d; bus_a.write_en = 1'b1;
    end else begin
      bus_b.addr = a; bus_b.wdata = d; bus_b.write_en = 1'b1;
    end
    @(negedge clk);
    bus_a.write_en = 1'b0;
    bus_b.write_en = 1'b0;
    $display("WRITE dut%0s addr=%04h data=%02h", sel ? "8" : "128", a, d);
  endtask

  task automatic bus_read(input bit sel, input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    if (!sel) begin
      bus_a.addr = a; bus_a.read_en = 1'b1; #1 d = bus_a.rdata; bus_a.read_en = 1'b0;
    end else begin
      bus_b.addr = a; bus_b.read_en = 1'b1; #1 d = bus_b.rdata; bus_b.read_en = 1'b0;
    end
    $display("READ  dut%0s addr=%04h data=%02h", sel ? "8" : "128", a, d);
  endtask

  task automatic load_bases();
    for (int b = 0; b < 128; b++) begin
      @(negedge clk);
      load_en_a = 1'b1; load_addr_a = 21'(b * 16384); load_data_a = 8'(b);
      load_en_b = (b < 8);
      load_addr_b = 17'((b % 8) * 16384); load_data_b = 8'(b % 8);
    end
    @(negedge clk);
    load_en_a = 1'b0;
    load_en_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_enabled_a !== 1'b0) begin
      failures++; $display("FAIL reset_ram_enabled_low got=%b exp=0", ram_enabled_a);
    end
    reset = 1'b1;
    load_bases();
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL reset_hi_bank got=%02h exp=01", d); end
    bus_read(0, 16'h0000, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_lo_bank got=%02h exp=00", d); end
    checks++;
    if (ram_enabled_a !== 1'b0) begin
      failures++; $display("FAIL reset_ram_enabled got=%b exp=0", ram_enabled_a);
    end
    bus_read(0, 16'hA000, d);
    checks++;
    if (d !== 8'hFF) begin failures++; $display("FAIL reset_ram_read got=%02h exp=FF", d); end
    bus_read(0, 16'h8000, d);
    checks++;
    if (d !== 8'hFF) begin failures++; $display("FAIL unmapped_read got=%02h exp=FF", d); end
    @(negedge clk);
    bus_a.addr = 16'h4000; bus_a.read_en = 1'b0;
    #1;
    checks++;
    if (bus_a.rdata !== 8'hFF) begin
      failures++; $display("FAIL idle_read got=%02h exp=FF", bus_a.rdata);
    end
  endtask

  task automatic test_bank_zero();
    logic [7:0] d;
    bus_write(0, 16'h2000, 8'h05);
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL bank1_select got=%02h exp=05", d); end
    bus_write(0, 16'h2000, 8'h00);
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL bank_zero_remap got=%02h exp=01", d); end
    bus_write(0, 16'h4000, 8'h01);
    bus_write(0, 16'h2000, 8'h20);
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h21) begin failures++; $display("FAIL bank_20_remap got=%02h exp=21", d); end
    bus_write(0, 16'h4000, 8'h00);
    bus_write(0, 16'h2000, 8'h01);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    bus_write(1, 16'h2000, 8'h1B);
    bus_read(1, 16'h4000, d);
    checks++;
    if (d !== 8'h03) begin failures++; $display("FAIL wrap_1b got=%02h exp=03", d); end
    bus_write(1, 16'h4000, 8'h01);
    bus_write(1, 16'h2000, 8'h02);
    bus_read(1, 16'h4000, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL wrap_bank2 got=%02h exp=02", d); end
  endtask

  task automatic test_ram();
    logic [7:0] d;
    bus_write(0, 16'h0000, 8'h0A);
    checks++;
    if (ram_enabled_a !== 1'b1) begin
      failures++; $display("FAIL ram_enable got=%b exp=1", ram_enabled_a);
    end
    bus_write(0, 16'h6000, 8'h01);
    bus_write(0, 16'h4000, 8'h00);
    bus_write(0, 16'hA123, 8'h11);
    bus_write(0, 16'h4000, 8'h02);
    bus_write(0, 16'hA123, 8'h5C);
    bus_read(0, 16'h0000, d);
    checks++;
    if (d !== 8'h40) begin failures++; $display("FAIL mode1_lo_bank2 got=%02h exp=40", d); end
    bus_write(0, 16'h4000, 8'h00);
    bus_read(0, 16'hA123, d);
    checks++;
    if (d !== 8'h11) begin failures++; $display("FAIL ram_bank0 got=%02h exp=11", d); end
    bus_write(0, 16'h4000, 8'h02);
    bus_read(0, 16'hA123, d);
    checks++;
    if (d !== 8'h5C) begin failures++; $display("FAIL ram_bank2 got=%02h exp=5C", d); end
    bus_write(0, 16'h0000, 8'h00);
    bus_read(0, 16'hA123, d);
    checks++;
    if (d !== 8'hFF) begin failures++; $display("FAIL ram_disabled_read got=%02h exp=FF", d); end
    checks++;
    if (ram_enabled_a !== 1'b0) begin
      failures++; $display("FAIL ram_disable got=%b exp=0", ram_enabled_a);
    end
    bus_write(0, 16'hA123, 8'h77);
    bus_write(0, 16'h0000, 8'h1A);
    bus_read(0, 16'hA123, d);
    checks++;
    if (d !== 8'h5C) begin failures++; $display("FAIL ram_write_dropped got=%02h exp=5C", d); end
    bus_write(0, 16'h0000, 8'h00);
    bus_write(0, 16'h6000, 8'h00);
    bus_write(0, 16'h4000, 8'h00);
  endtask

  task automatic test_mode1_low();
    logic [7:0] d;
    bus_write(0, 16'h4000, 8'h03);
    bus_write(0, 16'h2000, 8'h01);
    bus_write(0, 16'h6000, 8'h01);
    bus_read(0, 16'h0000, d);
    checks++;
    if (d !== 8'h60) begin failures++; $display("FAIL mode1_lo got=%02h exp=60", d); end
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h61) begin failures++; $display("FAIL mode1_hi got=%02h exp=61", d); end
    bus_write(0, 16'h6000, 8'h00);
    bus_read(0, 16'h0000, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL mode0_lo got=%02h exp=00", d); end
    bus_write(0, 16'h4000, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    @(negedge clk);
    bus_a.addr = 16'h2000; bus_a.wdata = 8'h09; bus_a.write_en = 1'b1;
    load_en_a = 1'b1; load_addr_a = 21'(9 * 16384); load_data_a = 8'hA9;
    @(negedge clk);
    bus_a.write_en = 1'b0;
    load_en_a = 1'b0;
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'hA9) begin failures++; $display("FAIL load_and_write got=%02h exp=A9", d); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    bus_write(0, 16'h0000, 8'h0A);
    bus_write(0, 16'h2000, 8'h07);
    bus_read(0, 16'h4000, d);
    checks++;
    if (d !== 8'h07) begin failures++; $display("FAIL pre_reset_bank got=%02h exp=07", d); end
    @(negedge clk);
    #2 reset = 1'b0;
    bus_a.addr = 16'h4000; bus_a.read_en = 1'b1;
    #1;
    checks++;
    if (ram_enabled_a !== 1'b0) begin
      failures++; $display("FAIL async_ram_enabled got=%b exp=0", ram_enabled_a);
    end
    checks++;
    if (bus_a.rdata !== 8'h01) begin
      failures++; $display("FAIL async_bank1 got=%02h exp=01", bus_a.rdata);
    end
    $display("RESET async assert: ram_enabled=%b rdata=%02h", ram_enabled_a, bus_a.rdata);
    bus_a.read_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_write(0, 16'h0000, 8'h0A);
    bus_write(0, 16'h6000, 8'h01);
    bus_write(0, 16'h4000, 8'h02);
    bus_read(0, 16'hA123, d);
    checks++;
    if (d !== 8'h5C) begin failures++; $display("FAIL ram_retained got=%02h exp=5C", d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus_a.addr = '0; bus_a.wdata = '0; bus_a.read_en = 1'b0; bus_a.write_en = 1'b0;
    bus_b.addr = '0; bus_b.wdata = '0; bus_b.read_en = 1'b0; bus_b.write_en = 1'b0;
    load_en_a = 1'b0; load_addr_a = '0; load_data_a = '0;
    load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
    #2;
    test_reset();
    test_bank_zero();
    test_wrap();
    test_ram();
    test_mode1_low();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
